// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I instruction fields into a 32-bit instruction word.
// The output is one register stage behind a valid/ready handshake, so the
// result appears one cycle after the request is accepted.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready request handshake (in_ready = !out_valid || out_ready)
//   in_imm_type       I=0 S=1 B=2 U=3 J=4, 5..7 = R-type
//   in_imm, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7
//                     instruction fields
//   out_valid/out_ready  result handshake
//   out_inst          encoded word (truncated immediate, even on error)
//   out_err           immediate out of range for its type (valid with out_valid)
//   err_count         saturating count of accepted out-of-range requests
//
// Build option: define IMM_RANGE_CHECK_EN to enable immediate range checking.
// Without it out_err and err_count stay at 0.
module inst_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_imm_type,
   input  logic [31:0] in_imm,
   input  logic [6:0]  in_opcode,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_err,
   output logic [7:0]  err_count
);

   localparam logic [2:0] T_I = 3'd0;
   localparam logic [2:0] T_S = 3'd1;
   localparam logic [2:0] T_B = 3'd2;
   localparam logic [2:0] T_U = 3'd3;
   localparam logic [2:0] T_J = 3'd4;

   logic        accept;
   logic [31:0] enc;

   // The output register may be refilled in the same cycle it is drained.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      enc = '0;
      case (in_imm_type)
         T_I: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         T_S: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         T_B: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
         T_U: enc = {in_imm[31:12], in_rd, in_opcode};
         T_J: enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                     in_rd, in_opcode};
         default: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_inst  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_inst  <= enc;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef IMM_RANGE_CHECK_EN
   logic range_err;

   // Each immediate must survive truncation to its field: the discarded
   // upper bits must be a pure sign extension, branch/jump offsets must be
   // even, and U-type may not carry low bits.
   always_comb begin
      range_err = 1'b0;
      case (in_imm_type)
         T_I, T_S: range_err = in_imm != {{20{in_imm[11]}}, in_imm[11:0]};
         T_B:      range_err = (in_imm != {{19{in_imm[12]}}, in_imm[12:0]}) || in_imm[0];
         T_U:      range_err = in_imm[11:0] != 12'd0;
         T_J:      range_err = (in_imm != {{11{in_imm[20]}}, in_imm[20:0]}) || in_imm[0];
         default:  range_err = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_err   <= 1'b0;
         err_count <= '0;
      end else if (accept) begin
         out_err <= range_err;
         if (range_err && err_count != 8'hff)
            err_count <= err_count + 8'd1;
      end
   end
`else
   assign out_err   = 1'b0;
   assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_imm_type;
   logic [31:0] in_imm;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;
   logic [7:0]  err_count;

   inst_encoder dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_imm_type(in_imm_type), .in_imm(in_imm), .in_opcode(in_opcode),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_err(out_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic        err;
      logic [7:0]  cnt;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          fails = 0;
   int          model_errs = 0;
   logic        rand_mode = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_inst;
   logic        prev_err;

`ifdef IMM_RANGE_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: place immediate bits by arithmetic, range via signed bounds.
   function automatic exp_t model(input logic [2:0] t, input logic [31:0] imm,
                                  input logic [31:0] op, rd, rs1, rs2, f3, f7);
      exp_t e;
      int   si;
      logic bad;
      si  = int'($signed(imm));
      bad = 1'b0;
      case (t)
         3'd0: begin
            e.inst = ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            bad = !(si >= -2048 && si <= 2047);
         end
         3'd1: begin
            e.inst = (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15)
                   | (f3 << 12) | ((imm & 32'h1f) << 7) | op;
            bad = !(si >= -2048 && si <= 2047);
         end
         3'd2: begin
            e.inst = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25)
                   | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7) | op;
            bad = !(si >= -4096 && si <= 4095) || (imm % 2 != 0);
         end
         3'd3: begin
            e.inst = (imm & 32'hfffff000) | (rd << 7) | op;
            bad = (imm % 4096) != 0;
         end
         3'd4: begin
            e.inst = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12)
                   | (rd << 7) | op;
            bad = !(si >= -(1 << 20) && si <= (1 << 20) - 1) || (imm % 2 != 0);
         end
         default: e.inst = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      endcase
      e.err = bad && CHECK_EN;
      e.cnt = 8'd0;
      return e;
   endfunction

   // Present a request and hold it until accepted; expected result is queued
   // at the acceptance cycle. use_lit substitutes a hand-computed word.
   task automatic send(input logic [2:0] t, input logic [31:0] imm, input logic [6:0] op,
                       input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic use_lit, input logic [31:0] lit);
      exp_t e;
      bit   done = 1'b0;
      in_imm_type = t; in_imm = imm; in_opcode = op; in_rd = rd;
      in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e = model(t, imm, 32'(op), 32'(rd), 32'(rs1), 32'(rs2), 32'(f3), 32'(f7));
            if (use_lit) e.inst = lit;
            if (e.err && model_errs < 255) model_errs++;
            e.cnt = 8'(model_errs);
            sb.push_back(e);
            done = 1'b1;
         end
         @(posedge clk); #1;
         if (rand_mode) out_ready = 1'($urandom);
      end
      if (!done) begin
         checks++; fails++;
         $display("FAIL accept_timeout: got no acceptance expected acceptance within 200 cycles");
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 100 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      logic [2:0]  t;
      logic [31:0] imm;
      logic [20:0] t21;
      logic [11:0] t12;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_imm_type = '0; in_imm = '0; in_opcode = '0; in_rd = '0;
      in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0;

      // Monitor: pops and compares on every transfer, checks hold stability.
      fork
         forever begin
            @(negedge clk);
            if (rst) begin
               prev_stall = 1'b0;
            end else begin
               chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
               if (prev_stall) begin
                  chk("hold_valid", 32'(out_valid), 32'd1);
                  chk("hold_inst", out_inst, prev_inst);
                  chk("hold_err", 32'(out_err), 32'(prev_err));
               end
               if (out_valid && out_ready) begin
                  if (sb.size() == 0) begin
                     checks++; fails++;
                     $display("FAIL unexpected_word: got %h expected no word", out_inst);
                  end else begin
                     exp_t e;
                     e = sb.pop_front();
                     chk("out_inst", out_inst, e.inst);
                     chk("out_err", 32'(out_err), 32'(e.err));
                     chk("err_count", 32'(err_count), 32'(e.cnt));
                  end
               end
               prev_stall = out_valid && !out_ready;
               prev_inst  = out_inst;
               prev_err   = out_err;
            end
         end
      join_none

      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #2 rst = 1'b0;
      @(posedge clk); #1;

      // Directed vectors with hand-encoded words.
      send(3'd0, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h00500093);
      send(3'd2, 32'hFFFFFFF8, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 1'b1, 32'hFE208CE3);
      send(3'd4, 32'h800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h001000EF);
      send(3'd0, 32'h800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h80000093);
      drain();

      // Back-to-back A then B with a two-cycle stall.
      out_ready = 1'b0;
      send(3'd3, 32'h12345000, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h123451B7);
      fork
         send(3'd7, 32'hdeadbeef, 7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 1'b1, 32'h407302B3);
         begin
            @(posedge clk); #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_hold_a", out_inst, 32'h123451B7);
            @(posedge clk); #1 out_ready = 1'b1;
            @(posedge clk); #1;
            chk("b_after_ready_valid", 32'(out_valid), 32'd1);
            chk("b_after_ready_inst", out_inst, 32'h407302B3);
         end
      join
      drain();

      // Reset while a word is held.
      out_ready = 1'b0;
      send(3'd0, 32'h800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h80000093);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_inst", out_inst, 32'd0);
      chk("midrst_err_count", 32'(err_count), 32'd0);
      sb.delete();
      model_errs = 0;
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;

      // Saturation: more range errors than the counter can hold.
      out_ready = 1'b1;
      for (int i = 0; i < 260; i++)
         send(3'd1, 32'h1000 + 32'(i), 7'h23, 5'd0, 5'(i), 5'(i >> 3), 3'd2, 7'd0, 1'b0, 32'd0);
      drain();

      // Randomized traffic with random back-pressure.
      rand_mode = 1'b1;
      for (int i = 0; i < 400; i++) begin
         t = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 4))
            0: imm = $urandom;
            1: begin t12 = 12'($urandom); imm = {{20{t12[11]}}, t12}; end
            2: begin t21 = 21'($urandom); imm = {{11{t21[20]}}, t21}; end
            3: imm = $urandom & 32'hfffff000;
            default: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
         endcase
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1 out_ready = 1'($urandom);
         end
         send(t, imm, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), 1'b0, 32'd0);
      end
      rand_mode = 1'b0;
      drain();
      @(posedge clk); #1;
      chk("idle_out_valid", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: the request fields are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: the encoder can accept a request this cycle.
REQ-005 SHALL have port in_imm_type, input, 3 bits: I=0, S=1, B=2, U=3, J=4; values 5-7 select R-type.
REQ-006 SHALL have ports in_imm (32 bits), in_opcode (7), in_rd (5), in_rs1 (5), in_rs2 (5), in_funct3 (3), in_funct7 (7), all inputs: the instruction fields.
REQ-007 SHALL have port out_valid, output, 1 bit: out_inst holds an encoded word.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts out_inst.
REQ-009 SHALL have port out_inst, output, 32 bits: the encoded RV32I instruction.
REQ-010 SHALL have port out_err, output, 1 bit: in_imm was out of range for its type; qualified by out_valid.
REQ-011 SHALL have port err_count, output, 8 bits: saturating count of range errors.

Function
REQ-012 SHALL make in_ready = !out_valid || out_ready, combinationally.
REQ-013 SHALL accept a request on a cycle with in_valid && in_ready, and register the result into out_inst/out_err with out_valid=1 on the next cycle (1-cycle latency).
REQ-014 SHALL sustain one word per cycle while out_ready=1.
REQ-015 SHALL hold out_inst and out_err stable while out_valid && !out_ready.
REQ-016 SHALL clear out_valid after out_ready when no new request is accepted in that cycle.
REQ-017 SHALL encode I-type as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-018 SHALL encode S-type as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-019 SHALL encode B-type as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-020 SHALL encode U-type as {imm[31:12], rd, opcode}.
REQ-021 SHALL encode J-type as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-022 SHALL encode types 5-7 as {funct7, rs2, rs1, funct3, rd, opcode}, ignoring in_imm.
REQ-023 SHALL silently drop imm bits not listed for the selected type.
REQ-024 SHALL apply these range rules (error when violated):
- I and S: imm must equal the sign extension of imm[11:0].
- B: imm must equal the sign extension of imm[12:0], and imm[0] must be 0.
- U: imm[11:0] must be 0.
- J: imm must equal the sign extension of imm[20:0], and imm[0] must be 0.
- R: never an error.
REQ-025 SHALL increment err_count by 1 on each accepted request with a range error, saturating at 255 with no wrap.
REQ-026 SHALL always emit the truncated encoding in out_inst, even when out_err=1.

Reset
REQ-027 SHALL, while rst=1, force out_valid=0, out_inst=0, out_err=0 and err_count=0, independent of clk.
REQ-028 SHALL discard any held word when reset is asserted mid-hold; in_ready=1 on the first cycle after release.

Configuration
REQ-029 SHALL implement range checking (REQ-024, REQ-025) only when IMM_RANGE_CHECK_EN is defined.
REQ-030 SHALL, without IMM_RANGE_CHECK_EN, keep the out_err and err_count ports, tie both to 0, and leave encoding and handshake unchanged.

Verification
REQ-031 SHALL cover I-type: opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_inst=0x00500093 one cycle after acceptance, out_err=0.
REQ-032 SHALL cover B-type: opcode=0x63, rs1=1, rs2=2, funct3=0, imm=0xFFFFFFF8 -> out_inst=0xFE208CE3.
REQ-033 SHALL cover J-type: opcode=0x6F, rd=1, imm=0x800 -> out_inst=0x001000EF.
REQ-034 SHALL cover back-to-back requests A then B with out_ready=0 for 2 cycles:
- A is held stable and in_ready=0 during the stall.
- B appears on the cycle after out_ready rises.
- No word is lost or duplicated.
REQ-035 SHALL cover I-type imm=0x800, opcode=0x13, rd=1:
- With IMM_RANGE_CHECK_EN: out_err=1, err_count 0->1, out_inst=0x80000093.
- Without it: out_err=0, err_count=0, out_inst=0x80000093.
REQ-036 SHALL cover rst pulsed while a word is held with out_ready=0 -> out_valid=0 immediately, err_count=0, in_ready=1 after release.
